vector_lsu: RTL

Vector load/store unit for the SIMD datapath. It accepts one whole-vector load or store from the execute stage and serializes it into `VEC_LANES` single-word accesses on the data-memory port. It then gathers load results into a vector response. It is the initiator side of the data-memory interface, which is a one-word port with a registered read that has 1-cycle latency and is valid only when write-enable is low.

---
 rtl/simd_mem_pkg.sv | 21 ++
 rtl/vector_lsu_if.sv | 43 ++++
 rtl/vec_gather_buffer.sv | 40 ++++
 rtl/vector_lsu.sv | 136 +++++++++++++
 4 files changed

// File: rtl/simd_mem_pkg.sv
// Shared types and sizing for the vector load/store unit.
// Optional build macro: LSU_ALIGN_CHECK_EN.
package simd_mem_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int VEC_LANES  = 4;
  localparam int WORD_BYTES = DATA_W / 8;
  localparam int LANE_IDX_W =
    (VEC_LANES > 1) ? $clog2(VEC_LANES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESP
  } lsu_state_t;

  typedef logic [VEC_LANES-1:0][DATA_W-1:0] lane_vec_t;

endpackage

// File: rtl/vector_lsu_if.sv
// Execute-side request/response bundle and data-memory port bundle.
// Optional build macro: LSU_ALIGN_CHECK_EN.
interface vlsu_req_if;
  import simd_mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  lane_vec_t         req_wdata;
  logic              resp_valid;
  logic              resp_err;
  lane_vec_t         resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

interface vlsu_mem_if;
  import simd_mem_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/vec_gather_buffer.sv
// Lane capture array for loads; the visible vector only updates on commit.
// Optional build macro: LSU_ALIGN_CHECK_EN (not used here).
module vec_gather_buffer
  import simd_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cap_en,
  input  logic                  i_commit,
  input  logic [LANE_IDX_W-1:0] i_cap_idx,
  input  logic [DATA_W-1:0]     i_cap_data,
  output lane_vec_t             o_rdata
);

  lane_vec_t r_stage;
  lane_vec_t r_out;
  lane_vec_t w_merge;

  always_comb begin
    w_merge = r_stage;
    if (i_cap_en)
      w_merge[i_cap_idx] = i_cap_data;
  end

  // Last lane is merged on the commit edge so it needs no extra stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage <= '0;
      r_out   <= '0;
    end else begin
      if (i_cap_en)
        r_stage <= w_merge;
      if (i_commit)
        r_out <= w_merge;
    end
  end

  assign o_rdata = r_out;

endmodule

// File: rtl/vector_lsu.sv
// Serializes one vector load/store into per-lane data-memory beats.
// Optional build macro: LSU_ALIGN_CHECK_EN (misaligned request -> error).
module vector_lsu
  import simd_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  vlsu_req_if.slave  req,
  vlsu_mem_if.master mem,
  output logic       busy
);

  lsu_state_t            r_state;
  lsu_state_t            w_state_nx;
  logic [LANE_IDX_W-1:0] r_lane;
  logic                  r_write;
  logic [ADDR_W-1:0]     r_base;
  lane_vec_t             r_wdata;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_misalign;
  logic                  w_ready;
  logic                  w_we;
  logic [ADDR_W-1:0]     w_addr;
  logic [DATA_W-1:0]     w_wdata;
  logic                  w_cap_en;
  logic                  w_commit;
  logic [LANE_IDX_W-1:0] w_cap_idx;

  assign w_accept = req.req_valid & w_ready;
  assign w_last   = (r_lane == LANE_IDX_W'(VEC_LANES - 1));

`ifdef LSU_ALIGN_CHECK_EN
  logic r_err;
  assign w_misalign = (req.req_addr[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_lane  <= '0;
      r_write <= 1'b0;
      r_base  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_accept) begin
        r_write <= req.req_write;
        r_base  <= req.req_addr & ~ADDR_W'(3);
        r_wdata <= req.req_wdata;
        r_lane  <= '0;
      end else if (r_state == ISSUE && !w_last) begin
        r_lane <= r_lane + LANE_IDX_W'(1);
      end
    end
  end

`ifdef LSU_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)
      r_err <= 1'b0;
    else if (w_accept)
      r_err <= w_misalign;
  end
`endif

  always_comb begin
    w_state_nx = r_state;
    w_ready    = 1'b0;
    w_we       = 1'b0;
    w_addr     = '0;
    w_wdata    = '0;
    w_cap_en   = 1'b0;
    w_commit   = 1'b0;
    w_cap_idx  = r_lane;
    unique case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (w_accept)
          w_state_nx = w_misalign ? RESP : ISSUE;
      end
      ISSUE: begin
        w_addr = r_base
               + ADDR_W'(r_lane) * ADDR_W'(WORD_BYTES);
        w_we   = r_write;
        if (r_write)
          w_wdata = r_wdata[r_lane];
        // Read data for lane i-1 arrives while lane i issues.
        if (!r_write && r_lane != '0) begin
          w_cap_en  = 1'b1;
          w_cap_idx = r_lane - LANE_IDX_W'(1);
        end
        if (w_last)
          w_state_nx = r_write ? RESP : DRAIN;
      end
      DRAIN: begin
        w_cap_en   = 1'b1;
        w_commit   = 1'b1;
        w_state_nx = RESP;
      end
      RESP: begin
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  assign req.req_ready  = w_ready;
  assign req.resp_valid = (r_state == RESP);
`ifdef LSU_ALIGN_CHECK_EN
  assign req.resp_err   = r_err & (r_state == RESP);
`else
  assign req.resp_err   = 1'b0;
`endif
  assign busy           = (r_state != IDLE);

  assign mem.mem_we    = w_we & ~rst;
  assign mem.mem_addr  = w_addr;
  assign mem.mem_wdata = w_wdata;

  vec_gather_buffer u_gather (
    .clk        (clk),
    .rst        (rst),
    .i_cap_en   (w_cap_en),
    .i_commit   (w_commit),
    .i_cap_idx  (w_cap_idx),
    .i_cap_data (mem.mem_rdata),
    .o_rdata    (req.resp_rdata)
  );

endmodule
